// File: rtl/axi_round_clip_multi.sv
// axi_round_clip_multi
// Narrows NUM_CH packed signed samples from WIDTH_IN to WIDTH_OUT bits on an
// AXI-Stream path. The block has two register stages:
//   stage 1 drops DROP_LSB bits using the rounding mode sampled with the beat
//   stage 2 clips to the signed output range and flags the beat if any
//           channel saturated
// sat_count counts delivered beats that had o_tsat set and holds at all-ones.
//
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   clear            synchronous flush of both stages and sat_count
//   round_mode       0 floor, 1 round half up, 2 round half to even, 3 as 0
//   i_t*             input stream (channel 0 in the LSBs of i_tdata)
//   o_t*             output stream; o_tsat is a per-beat saturation flag
//   sat_count        saturating count of delivered saturated beats
module axi_round_clip_multi #(
    parameter int NUM_CH    = 2,
    parameter int WIDTH_IN  = 24,
    parameter int WIDTH_OUT = 16,
    parameter int DROP_LSB  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic [1:0]                    round_mode,
    input  logic [NUM_CH*WIDTH_IN-1:0]    i_tdata,
    input  logic                          i_tlast,
    input  logic                          i_tvalid,
    output logic                          i_tready,
    output logic [NUM_CH*WIDTH_OUT-1:0]   o_tdata,
    output logic                          o_tlast,
    output logic                          o_tsat,
    output logic                          o_tvalid,
    input  logic                          o_tready,
    output logic [CNT_WIDTH-1:0]          sat_count
);

    localparam int WX = WIDTH_IN + 1;            // sign-extended input width
    localparam int WR = WIDTH_IN - DROP_LSB + 1; // rounded width, cannot wrap

    logic                     rdy_en;
    logic                     s1_valid;
    logic                     s2_valid;
    logic                     s1_last;
    logic [NUM_CH*WR-1:0]     s1_r;
    logic [NUM_CH*WR-1:0]     r_in;
    logic [NUM_CH*WIDTH_OUT-1:0] clip_out;
    logic [NUM_CH-1:0]        clip_flag;
    logic                     s2_adv;
    logic                     s1_adv;
    logic                     accept;

    assign s2_adv   = ~s2_valid | o_tready;
    assign s1_adv   = ~s1_valid | s2_adv;
    // rdy_en keeps the input closed until the first edge after reset.
    assign i_tready = rdy_en & s1_adv;
    assign accept   = i_tvalid & i_tready & ~clear;
    assign o_tvalid = s2_valid;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : gen_ch
        logic [WX-1:0] x;
        logic [WR-1:0] r;
        logic          fits;

        assign x = {i_tdata[ch*WIDTH_IN+WIDTH_IN-1], i_tdata[ch*WIDTH_IN +: WIDTH_IN]};

        if (DROP_LSB == 0) begin : g_pass
            assign r_in[ch*WR +: WR] = x;
        end else begin : g_round
            logic tie;
            logic up;

            // (x + half) >>> D equals floor(x) plus the top dropped bit.
            // A tie is dropped bits == 100..0; shifting left by one discards
            // the top dropped bit so the rest can be tested for zero.
            assign tie = x[DROP_LSB-1] & ~|(x[DROP_LSB-1:0] << 1);

            always_comb begin
                up = 1'b0;
                case (round_mode)
                    2'd1:    up = x[DROP_LSB-1];
                    2'd2:    up = x[DROP_LSB-1] & ~(tie & ~x[DROP_LSB]);
                    default: up = 1'b0;
                endcase
            end

            assign r_in[ch*WR +: WR] = x[WX-1:DROP_LSB] + {{(WR-1){1'b0}}, up};
        end

        // The value fits when every bit from the output sign bit upward
        // matches the sign.
        assign r    = s1_r[ch*WR +: WR];
        assign fits = (&r[WR-1:WIDTH_OUT-1]) | ~(|r[WR-1:WIDTH_OUT-1]);
        assign clip_flag[ch] = ~fits;
        assign clip_out[ch*WIDTH_OUT +: WIDTH_OUT] =
            fits ? r[WIDTH_OUT-1:0] : {r[WR-1], {(WIDTH_OUT-1){~r[WR-1]}}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_r     <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_r    <= r_in;
                s1_last <= i_tlast;
            end
        end
    end

    // Output registers only load with a real beat, so they hold steady while
    // the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            o_tdata  <= '0;
            o_tlast  <= 1'b0;
            o_tsat   <= 1'b0;
        end else if (clear) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                o_tdata <= clip_out;
                o_tlast <= s1_last;
                o_tsat  <= |clip_flag;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_count <= '0;
        end else if (clear) begin
            sat_count <= '0;
        end else if (s2_valid & o_tready & o_tsat & ~(&sat_count)) begin
            sat_count <= sat_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_axi_round_clip_multi.sv
module tb_axi_round_clip_multi;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [1:0]  round_mode = 2'd0;
    logic [47:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tsat;
    logic        o_tvalid;
    logic        o_tready = 1'b1;
    logic [15:0] sat_count;

    logic        c_i_tready;
    logic [31:0] c_o_tdata;
    logic        c_o_tlast;
    logic        c_o_tsat;
    logic        c_o_tvalid;
    logic [3:0]  c_sat_count;

    int n_cmp = 0;
    int n_err = 0;
    int acc;
    logic [33:0] expq[$];

    always #5 clk = ~clk;

    axi_round_clip_multi dut (
        .clk(clk), .reset(reset), .clear(clear), .round_mode(round_mode),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tsat(o_tsat), .o_tvalid(o_tvalid),
        .o_tready(o_tready), .sat_count(sat_count)
    );

    axi_round_clip_multi #(.CNT_WIDTH(4)) dut_c (
        .clk(clk), .reset(reset), .clear(clear), .round_mode(round_mode),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(c_i_tready),
        .o_tdata(c_o_tdata), .o_tlast(c_o_tlast), .o_tsat(c_o_tsat), .o_tvalid(c_o_tvalid),
        .o_tready(o_tready), .sat_count(c_sat_count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: integer floor division by 16 with explicit tie handling.
    function automatic logic [32:0] mdl_beat(input logic [47:0] d, input logic [1:0] m);
        logic [31:0] o;
        logic [31:0] rv;
        logic        s;
        int x, q, r;
        o = '0;
        s = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            x = int'($signed(d[ch*24 +: 24]));
            q = x >>> 4;
            if (m == 2'd1 || (m == 2'd2 && !((x & 15) == 8 && (q & 1) == 0)))
                r = (x + 8) >>> 4;
            else
                r = q;
            if (r > 32767) begin
                r = 32767;
                s = 1'b1;
            end else if (r < -32768) begin
                r = -32768;
                s = 1'b1;
            end
            rv = r;
            o[ch*16 +: 16] = rv[15:0];
        end
        return {s, o};
    endfunction

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    // rmode 0: always ready; 1: random valid/ready/mode/last; 2: stalled 8 cycles
    task automatic stream(input int n, input int rmode, input bit clipd);
        int got;
        expq = {};
        acc  = 0;
        got  = 0;
        fork
            begin : drv
                int i = 0;
                bit holding = 0;
                logic [47:0] d = '0;
                logic [1:0]  m = 2'd1;
                logic        l = 1'b0;
                logic [31:0] r1, r2, r3;
                for (int c = 0; c < 8000 && i < n; c++) begin
                    @(negedge clk);
                    if (!holding) begin
                        r3 = $urandom();
                        if (rmode == 1 && r3[5:4] == 2'd0) begin
                            i_tvalid = 1'b0;
                        end else begin
                            r1 = $urandom();
                            r2 = $urandom();
                            d = clipd ? {24'h7FFFFF, 24'h800000} : {r1[23:0], r2[23:0]};
                            m = (rmode == 1) ? r3[1:0] : 2'd1;
                            l = (rmode == 1) ? r3[2] : (i == n - 1);
                            i_tdata = d;
                            round_mode = m;
                            i_tlast = l;
                            i_tvalid = 1'b1;
                            holding = 1;
                        end
                    end
                    #1;
                    if (i_tvalid && i_tready) begin
                        expq.push_back({l, mdl_beat(d, m)});
                        acc++;
                        i++;
                        holding = 0;
                    end
                end
                @(posedge clk);
                #1 i_tvalid = 1'b0;
            end
            begin : mon
                bit stalled = 0;
                logic [34:0] held = '0;
                logic [33:0] e;
                logic [31:0] rr;
                for (int c = 0; c < 8000 && got < n; c++) begin
                    @(negedge clk);
                    if (rmode == 2 && c == 8) begin
                        chk("stall_accepted", acc, 2);
                        chk("stall_ready", i_tready, 0);
                    end
                    rr = $urandom();
                    if (rmode == 2 && c < 8) o_tready = 1'b0;
                    else if (rmode == 1) o_tready = rr[0];
                    else o_tready = 1'b1;
                    #1;
                    if (stalled)
                        chk("stall_stable", {o_tvalid, o_tlast, o_tsat, o_tdata}, held);
                    if (o_tvalid && o_tready) begin
                        if (expq.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL extra_beat: got %0h expected none", o_tdata);
                        end else begin
                            e = expq.pop_front();
                            chk($sformatf("beat%0d", got), {o_tlast, o_tsat, o_tdata}, e);
                        end
                        got++;
                    end
                    stalled = o_tvalid && !o_tready;
                    held = {o_tvalid, o_tlast, o_tsat, o_tdata};
                end
                chk("stream_beats", got, n);
            end
        join
        o_tready = 1'b1;
        chk("stream_drained", expq.size(), 0);
    endtask

    typedef struct {
        logic [47:0] d;
        logic [1:0]  m;
        logic        l;
        logic [31:0] e;
        logic        s;
    } vec_t;

    vec_t vt[16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{48'h000000_000018, 2'd0, 1'b0, 32'h0000_0001, 1'b0};
        vt[1]  = '{48'h000000_000018, 2'd1, 1'b0, 32'h0000_0002, 1'b0};
        vt[2]  = '{48'h000000_000018, 2'd2, 1'b0, 32'h0000_0002, 1'b0};
        vt[3]  = '{48'h000000_000028, 2'd0, 1'b0, 32'h0000_0002, 1'b0};
        vt[4]  = '{48'h000000_000028, 2'd1, 1'b0, 32'h0000_0003, 1'b0};
        vt[5]  = '{48'h000000_000028, 2'd2, 1'b1, 32'h0000_0002, 1'b0};
        vt[6]  = '{48'h000000_FFFFE8, 2'd0, 1'b0, 32'h0000_FFFE, 1'b0};
        vt[7]  = '{48'h000000_FFFFE8, 2'd1, 1'b0, 32'h0000_FFFF, 1'b0};
        vt[8]  = '{48'h000000_FFFFE8, 2'd2, 1'b0, 32'h0000_FFFE, 1'b0};
        vt[9]  = '{48'h000000_000028, 2'd3, 1'b1, 32'h0000_0002, 1'b0};
        vt[10] = '{48'h000000_7FFFFF, 2'd1, 1'b0, 32'h0000_7FFF, 1'b1};
        vt[11] = '{48'h000000_800000, 2'd0, 1'b0, 32'h0000_8000, 1'b1};
        vt[12] = '{48'h000000_07FFF0, 2'd0, 1'b0, 32'h0000_7FFF, 1'b0};
        vt[13] = '{48'h000000_080000, 2'd0, 1'b1, 32'h0000_7FFF, 1'b1};
        vt[14] = '{48'h7FFFFF_000010, 2'd1, 1'b0, 32'h7FFF_0001, 1'b1};
        vt[15] = '{48'h000010_7FFFFF, 2'd1, 1'b1, 32'h0001_7FFF, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_valid", o_tvalid, 0);
        chk("rst_data", o_tdata, 0);
        chk("rst_last", o_tlast, 0);
        chk("rst_sat", o_tsat, 0);
        chk("rst_count", sat_count, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", i_tready, 1);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            i_tdata = vt[i].d;
            round_mode = vt[i].m;
            i_tlast = vt[i].l;
            i_tvalid = 1'b1;
            #1 chk($sformatf("vec%0d_ready", i), i_tready, 1);
            @(posedge clk);
            #1;
            i_tvalid = 1'b0;
            round_mode = 2'd1;
            @(negedge clk);
            chk($sformatf("vec%0d_lat1", i), o_tvalid, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), o_tvalid, 1);
            chk($sformatf("vec%0d_data", i), o_tdata, vt[i].e);
            chk($sformatf("vec%0d_sat", i), o_tsat, vt[i].s);
            chk($sformatf("vec%0d_last", i), o_tlast, vt[i].l);
            if (i == 13) begin
                @(negedge clk);
                chk("clip_count", sat_count, 3);
            end
        end
        @(negedge clk);
        chk("vec_count", sat_count, 5);

        stream(5, 2, 0);
        stream(1000, 1, 0);

        pulse_clear();
        @(negedge clk);
        chk("clear_idle_count", sat_count, 0);
        stream(20, 0, 1);
        @(negedge clk);
        chk("cnt16_count", sat_count, 20);
        chk("cnt4_hold", c_sat_count, 4'hF);

        @(negedge clk);
        o_tready = 1'b0;
        i_tdata = {24'h7FFFFF, 24'h000123};
        round_mode = 2'd1;
        i_tlast = 1'b0;
        i_tvalid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("flush_pre_valid", o_tvalid, 1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        @(negedge clk);
        chk("flush_valid", o_tvalid, 0);
        chk("flush_count", sat_count, 0);
        chk("flush_count4", c_sat_count, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("flush_gone%0d", k), o_tvalid, 0);
        end

        @(negedge clk);
        o_tready = 1'b1;
        i_tdata = {24'h7FFFFF, 24'h000000};
        round_mode = 2'd0;
        i_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        chk("arst_pre_valid", o_tvalid, 1);
        chk("arst_pre_count", sat_count, 1);
        reset = 1'b1;
        #1;
        chk("arst_valid", o_tvalid, 0);
        chk("arst_count", sat_count, 0);
        chk("arst_data", o_tdata, 0);
        i_tvalid = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk);
        chk("arst_ready", i_tready, 1);
        chk("arst_idle", o_tvalid, 0);
        stream(10, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
